// File: rtl/thunderbird_light_decoder_if.sv
// ---------------------------------------------------------------------------
// thunderbird_light_decoder_if
//
// Lamp-bus bundle between a Thunderbird tail-light source and the receive-side
// sequence checker. Signal names follow the lamp-bus naming used system-wide.
//
//   L_lights  [2:0]       left lamp lines, bit0 = innermost lamp
//   R_lights  [2:0]       right lamp lines, bit0 = innermost lamp
//   clr_cnt               synchronous clear of the four event counters
//   mode      [1:0]       class of last sampled pattern (00 idle, 01 left,
//                         10 right, 11 hazard)
//   left_done             pulse: complete left sequence observed
//   right_done            pulse: complete right sequence observed
//   haz_seen              pulse: hazard pattern accepted
//   seq_err               pulse: illegal pattern or transition
//   in_sync               high while the checker is tracking
//   left_cnt, right_cnt,
//   haz_cnt, err_cnt      saturating event counters, CNT_W bits each
//
// master : lamp source / bench side (drives lamps and clr_cnt)
// slave  : checker side (drives status, pulses and counters)
// ---------------------------------------------------------------------------
interface thunderbird_light_decoder_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       L_lights;
  logic [2:0]       R_lights;
  logic             clr_cnt;
  logic [1:0]       mode;
  logic             left_done;
  logic             right_done;
  logic             haz_seen;
  logic             seq_err;
  logic             in_sync;
  logic [CNT_W-1:0] left_cnt;
  logic [CNT_W-1:0] right_cnt;
  logic [CNT_W-1:0] haz_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output L_lights, R_lights, clr_cnt,
    input  mode, left_done, right_done, haz_seen, seq_err, in_sync,
    input  left_cnt, right_cnt, haz_cnt, err_cnt
  );

  modport slave (
    input  L_lights, R_lights, clr_cnt,
    output mode, left_done, right_done, haz_seen, seq_err, in_sync,
    output left_cnt, right_cnt, haz_cnt, err_cnt
  );
endinterface

// File: rtl/thunderbird_light_decoder.sv
// ---------------------------------------------------------------------------
// thunderbird_light_decoder
//
// Receive-side monitor for the Thunderbird tail-light lamp bus. Every rising
// edge it classifies the six lamp lines, advances a sequence-tracking state
// machine, pulses on completed left/right/hazard sequences, flags illegal
// patterns or transitions, and keeps saturating event counters. All outputs
// are registered and reflect the pattern sampled on the previous edge.
//
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-low reset
//   bus    thunderbird_light_decoder_if.slave (lamp inputs, clr_cnt, status,
//          pulses and counters -- see the interface header)
// ---------------------------------------------------------------------------
module thunderbird_light_decoder #(
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  thunderbird_light_decoder_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Lamp pattern classes. LR = {L_lights, R_lights}.
  typedef enum logic [3:0] {
    P_Z, P_A1, P_A2, P_A3, P_B1, P_B2, P_B3, P_H, P_ILL
  } pat_e;

  // Each state names the last accepted pattern; SYNC means "waiting for Z".
  typedef enum logic [3:0] {
    S_SYNC, S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HZ
  } state_e;

  state_e           r_state;
  logic [1:0]       r_mode;
  logic             r_left_done;
  logic             r_right_done;
  logic             r_haz_seen;
  logic             r_seq_err;
  logic             r_in_sync;
  logic [CNT_W-1:0] r_left_cnt;
  logic [CNT_W-1:0] r_right_cnt;
  logic [CNT_W-1:0] r_haz_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  pat_e       w_cls;
  state_e     w_next_state;
  logic       w_legal;
  logic       w_left;
  logic       w_right;
  logic       w_haz;
  logic       w_err;
  logic [1:0] w_mode;

  // -------------------------------------------------------------------------
  // Pattern classifier
  // -------------------------------------------------------------------------
  always_comb begin
    case ({bus.L_lights, bus.R_lights})
      6'b000_000: w_cls = P_Z;
      6'b001_000: w_cls = P_A1;
      6'b011_000: w_cls = P_A2;
      6'b111_000: w_cls = P_A3;
      6'b000_001: w_cls = P_B1;
      6'b000_011: w_cls = P_B2;
      6'b000_111: w_cls = P_B3;
      6'b111_111: w_cls = P_H;
      default:    w_cls = P_ILL;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state and pulse logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_legal      = 1'b0;
    w_left       = 1'b0;
    w_right      = 1'b0;
    w_haz        = 1'b0;
    w_err        = 1'b0;
    w_mode       = r_mode;

    // mode follows the sampled class every edge; ILL keeps the old value.
    case (w_cls)
      P_Z:              w_mode = 2'b00;
      P_A1, P_A2, P_A3: w_mode = 2'b01;
      P_B1, P_B2, P_B3: w_mode = 2'b10;
      P_H:              w_mode = 2'b11;
      default:          w_mode = r_mode;
    endcase

    case (r_state)
      S_SYNC: begin
        // Resynchronising: nothing is an error, only Z re-arms tracking.
        w_legal = 1'b1;
        if (w_cls == P_Z) w_next_state = S_IDLE;
      end
      S_IDLE: begin
        w_legal = 1'b1;
        case (w_cls)
          P_Z:     w_next_state = S_IDLE;
          P_A1:    w_next_state = S_L1;
          P_B1:    w_next_state = S_R1;
          P_H:     w_next_state = S_HZ;
          default: w_legal      = 1'b0;
        endcase
      end
      S_L1: begin
        if (w_cls == P_A2)     begin w_legal = 1'b1; w_next_state = S_L2; end
        else if (w_cls == P_H) begin w_legal = 1'b1; w_next_state = S_HZ; end
      end
      S_L2: begin
        if (w_cls == P_A3) begin
          w_legal      = 1'b1;
          w_next_state = S_L3;
          w_left       = 1'b1;
        end else if (w_cls == P_H) begin
          w_legal      = 1'b1;
          w_next_state = S_HZ;
        end
      end
      S_R1: begin
        if (w_cls == P_B2)     begin w_legal = 1'b1; w_next_state = S_R2; end
        else if (w_cls == P_H) begin w_legal = 1'b1; w_next_state = S_HZ; end
      end
      S_R2: begin
        if (w_cls == P_B3) begin
          w_legal      = 1'b1;
          w_next_state = S_R3;
          w_right      = 1'b1;
        end else if (w_cls == P_H) begin
          w_legal      = 1'b1;
          w_next_state = S_HZ;
        end
      end
      S_L3, S_R3, S_HZ: begin
        if (w_cls == P_Z) begin w_legal = 1'b1; w_next_state = S_IDLE; end
      end
      default: begin
        w_legal      = 1'b1;
        w_next_state = S_SYNC;
      end
    endcase

    if (!w_legal) begin
      // An offending Z is itself a valid starting point, so go straight to
      // IDLE instead of waiting in SYNC for another Z.
      w_err        = 1'b1;
      w_next_state = (w_cls == P_Z) ? S_IDLE : S_SYNC;
    end

    // HZ never accepts H, so any legal arrival in HZ is a fresh hazard.
    w_haz = w_legal && (w_next_state == S_HZ) && (r_state != S_SYNC);
  end

  // Counter update: clear beats increment, increment stops at all-ones.
  function automatic logic [CNT_W-1:0] f_cnt_next(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic             clr
  );
    if (clr)                        return '0;
    else if (inc && cnt != CNT_MAX) return cnt + 1'b1;
    else                            return cnt;
  endfunction

  // -------------------------------------------------------------------------
  // State, output and counter registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), so it is not in
    // the sensitivity list.
    if (!reset) begin
      r_state      <= S_SYNC;
      r_mode       <= 2'b00;
      r_left_done  <= 1'b0;
      r_right_done <= 1'b0;
      r_haz_seen   <= 1'b0;
      r_seq_err    <= 1'b0;
      r_in_sync    <= 1'b0;
      r_left_cnt   <= '0;
      r_right_cnt  <= '0;
      r_haz_cnt    <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_next_state;
      r_mode       <= w_mode;
      r_left_done  <= w_left;
      r_right_done <= w_right;
      r_haz_seen   <= w_haz;
      r_seq_err    <= w_err;
      r_in_sync    <= (w_next_state != S_SYNC);
      r_left_cnt   <= f_cnt_next(r_left_cnt,  w_left,  bus.clr_cnt);
      r_right_cnt  <= f_cnt_next(r_right_cnt, w_right, bus.clr_cnt);
      r_haz_cnt    <= f_cnt_next(r_haz_cnt,   w_haz,   bus.clr_cnt);
      r_err_cnt    <= f_cnt_next(r_err_cnt,   w_err,   bus.clr_cnt);
    end
  end

  assign bus.mode       = r_mode;
  assign bus.left_done  = r_left_done;
  assign bus.right_done = r_right_done;
  assign bus.haz_seen   = r_haz_seen;
  assign bus.seq_err    = r_seq_err;
  assign bus.in_sync    = r_in_sync;
  assign bus.left_cnt   = r_left_cnt;
  assign bus.right_cnt  = r_right_cnt;
  assign bus.haz_cnt    = r_haz_cnt;
  assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_thunderbird_light_decoder.sv
// ---------------------------------------------------------------------------
// tb_thunderbird_light_decoder
//
// Directed bench for thunderbird_light_decoder with CNT_W = 2 so counter
// saturation is reachable in a few cycles. Inputs change 1 time unit after a
// rising edge; outputs are read at that same point, i.e. they reflect the
// pattern sampled on the edge just passed.
// ---------------------------------------------------------------------------
module tb_thunderbird_light_decoder;

  localparam int CNT_W = 2;

  localparam logic [5:0] LR_Z   = 6'b000_000;
  localparam logic [5:0] LR_A1  = 6'b001_000;
  localparam logic [5:0] LR_A2  = 6'b011_000;
  localparam logic [5:0] LR_A3  = 6'b111_000;
  localparam logic [5:0] LR_B1  = 6'b000_001;
  localparam logic [5:0] LR_B2  = 6'b000_011;
  localparam logic [5:0] LR_B3  = 6'b000_111;
  localparam logic [5:0] LR_H   = 6'b111_111;
  localparam logic [5:0] LR_ILL = 6'b010_000;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  thunderbird_light_decoder_if #(.CNT_W(CNT_W)) bus ();

  thunderbird_light_decoder #(.CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one lamp pattern, let one edge sample it, settle past the edge.
  task automatic step(input logic [5:0] lr);
    {bus.L_lights, bus.R_lights} = lr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.clr_cnt = 1'b0;
    {bus.L_lights, bus.R_lights} = LR_Z;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.mode !== 2'b00) begin n_fail++; $display("FAIL reset_mode: got %b want 00", bus.mode); end
    n_checks++; if ({bus.left_done, bus.right_done, bus.haz_seen, bus.seq_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 0000", {bus.left_done, bus.right_done, bus.haz_seen, bus.seq_err}); end
    n_checks++; if (bus.in_sync !== 1'b0) begin n_fail++; $display("FAIL reset_in_sync: got %b want 0", bus.in_sync); end
    n_checks++; if ({bus.left_cnt, bus.right_cnt, bus.haz_cnt, bus.err_cnt} !== 8'h00) begin
      n_fail++; $display("FAIL reset_counters: got %h want 00", {bus.left_cnt, bus.right_cnt, bus.haz_cnt, bus.err_cnt}); end
  endtask

  task automatic test_left_sequence();
    logic [5:0] pat [5];
    logic [1:0] exp_mode [5];
    logic       exp_done [5];
    pat      = '{LR_Z, LR_A1, LR_A2, LR_A3, LR_Z};
    exp_mode = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(pat[i]);
      n_checks++; if (bus.mode !== exp_mode[i]) begin n_fail++; $display("FAIL left_mode[%0d]: got %b want %b", i, bus.mode, exp_mode[i]); end
      n_checks++; if (bus.left_done !== exp_done[i]) begin n_fail++; $display("FAIL left_done[%0d]: got %b want %b", i, bus.left_done, exp_done[i]); end
      n_checks++; if (bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL left_seq_err[%0d]: got %b want 0", i, bus.seq_err); end
      n_checks++; if (bus.in_sync !== 1'b1) begin n_fail++; $display("FAIL left_in_sync[%0d]: got %b want 1", i, bus.in_sync); end
    end
    n_checks++; if (bus.left_cnt !== 2'd1) begin n_fail++; $display("FAIL left_cnt: got %0d want 1", bus.left_cnt); end
    n_checks++; if (bus.err_cnt !== 2'd0) begin n_fail++; $display("FAIL left_err_cnt: got %0d want 0", bus.err_cnt); end
  endtask

  task automatic test_hazard_abort();
    logic [5:0] pat [5];
    logic [1:0] exp_mode [5];
    logic       exp_haz [5];
    pat      = '{LR_Z, LR_B1, LR_B2, LR_H, LR_Z};
    exp_mode = '{2'b00, 2'b10, 2'b10, 2'b11, 2'b00};
    exp_haz  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(pat[i]);
      n_checks++; if (bus.mode !== exp_mode[i]) begin n_fail++; $display("FAIL abort_mode[%0d]: got %b want %b", i, bus.mode, exp_mode[i]); end
      n_checks++; if (bus.haz_seen !== exp_haz[i]) begin n_fail++; $display("FAIL abort_haz_seen[%0d]: got %b want %b", i, bus.haz_seen, exp_haz[i]); end
      n_checks++; if (bus.right_done !== 1'b0) begin n_fail++; $display("FAIL abort_right_done[%0d]: got %b want 0", i, bus.right_done); end
      n_checks++; if (bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL abort_seq_err[%0d]: got %b want 0", i, bus.seq_err); end
    end
    n_checks++; if (bus.haz_cnt !== 2'd1) begin n_fail++; $display("FAIL abort_haz_cnt: got %0d want 1", bus.haz_cnt); end
    n_checks++; if (bus.right_cnt !== 2'd0) begin n_fail++; $display("FAIL abort_right_cnt: got %0d want 0", bus.right_cnt); end
  endtask

  task automatic test_illegal_pattern();
    logic [5:0] pat [4];
    logic       exp_err [4];
    logic       exp_sync [4];
    logic [1:0] exp_mode [4];
    pat      = '{LR_Z, LR_ILL, LR_A1, LR_Z};
    exp_err  = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp_sync = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_mode = '{2'b00, 2'b00, 2'b01, 2'b00};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(pat[i]);
      n_checks++; if (bus.seq_err !== exp_err[i]) begin n_fail++; $display("FAIL ill_seq_err[%0d]: got %b want %b", i, bus.seq_err, exp_err[i]); end
      n_checks++; if (bus.in_sync !== exp_sync[i]) begin n_fail++; $display("FAIL ill_in_sync[%0d]: got %b want %b", i, bus.in_sync, exp_sync[i]); end
      n_checks++; if (bus.mode !== exp_mode[i]) begin n_fail++; $display("FAIL ill_mode[%0d]: got %b want %b", i, bus.mode, exp_mode[i]); end
    end
    n_checks++; if (bus.err_cnt !== 2'd1) begin n_fail++; $display("FAIL ill_err_cnt: got %0d want 1", bus.err_cnt); end
  endtask

  task automatic test_illegal_transition();
    logic [5:0] pat [7];
    logic       exp_err [7];
    logic       exp_sync [7];
    logic       exp_rdone [7];
    pat       = '{LR_Z, LR_A1, LR_A1, LR_Z, LR_B1, LR_B2, LR_B3};
    exp_err   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_sync  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_rdone = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(pat[i]);
      n_checks++; if (bus.seq_err !== exp_err[i]) begin n_fail++; $display("FAIL xtn_seq_err[%0d]: got %b want %b", i, bus.seq_err, exp_err[i]); end
      n_checks++; if (bus.in_sync !== exp_sync[i]) begin n_fail++; $display("FAIL xtn_in_sync[%0d]: got %b want %b", i, bus.in_sync, exp_sync[i]); end
      n_checks++; if (bus.right_done !== exp_rdone[i]) begin n_fail++; $display("FAIL xtn_right_done[%0d]: got %b want %b", i, bus.right_done, exp_rdone[i]); end
    end
    step(LR_Z);
    n_checks++; if (bus.right_done !== 1'b0) begin n_fail++; $display("FAIL xtn_right_done_clear: got %b want 0", bus.right_done); end
    n_checks++; if (bus.right_cnt !== 2'd1) begin n_fail++; $display("FAIL xtn_right_cnt: got %0d want 1", bus.right_cnt); end
    n_checks++; if (bus.err_cnt !== 2'd1) begin n_fail++; $display("FAIL xtn_err_cnt: got %0d want 1", bus.err_cnt); end
  endtask

  // Held hazard is an error with no second haz_seen; an early Z after A1 is
  // an error that lands in IDLE, so in_sync stays high.
  task automatic test_back_to_back();
    do_reset();
    step(LR_Z);
    step(LR_H);
    n_checks++; if (bus.haz_seen !== 1'b1) begin n_fail++; $display("FAIL b2b_first_haz: got %b want 1", bus.haz_seen); end
    step(LR_H);
    n_checks++; if (bus.haz_seen !== 1'b0) begin n_fail++; $display("FAIL b2b_held_haz: got %b want 0", bus.haz_seen); end
    n_checks++; if (bus.seq_err !== 1'b1) begin n_fail++; $display("FAIL b2b_held_err: got %b want 1", bus.seq_err); end
    n_checks++; if (bus.in_sync !== 1'b0) begin n_fail++; $display("FAIL b2b_held_sync: got %b want 0", bus.in_sync); end
    step(LR_Z);
    step(LR_A1);
    step(LR_Z);
    n_checks++; if (bus.seq_err !== 1'b1) begin n_fail++; $display("FAIL b2b_early_z_err: got %b want 1", bus.seq_err); end
    n_checks++; if (bus.in_sync !== 1'b1) begin n_fail++; $display("FAIL b2b_early_z_sync: got %b want 1", bus.in_sync); end
    step(LR_A1);
    n_checks++; if (bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL b2b_restart_err: got %b want 0", bus.seq_err); end
    n_checks++; if (bus.err_cnt !== 2'd2) begin n_fail++; $display("FAIL b2b_err_cnt: got %0d want 2", bus.err_cnt); end
    n_checks++; if (bus.haz_cnt !== 2'd1) begin n_fail++; $display("FAIL b2b_haz_cnt: got %0d want 1", bus.haz_cnt); end
  endtask

  task automatic test_saturation_clear();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    step(LR_Z);
    for (int i = 0; i < 5; i++) begin
      step(LR_H);
      n_checks++; if (bus.haz_seen !== 1'b1) begin n_fail++; $display("FAIL sat_haz_seen[%0d]: got %b want 1", i, bus.haz_seen); end
      n_checks++; if (bus.haz_cnt !== exp_cnt[i]) begin n_fail++; $display("FAIL sat_haz_cnt[%0d]: got %0d want %0d", i, bus.haz_cnt, exp_cnt[i]); end
      step(LR_Z);
    end
    bus.clr_cnt = 1'b1;
    step(LR_H);
    bus.clr_cnt = 1'b0;
    n_checks++; if (bus.haz_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_haz_cnt: got %0d want 0", bus.haz_cnt); end
    n_checks++; if (bus.haz_seen !== 1'b1) begin n_fail++; $display("FAIL clr_haz_seen: got %b want 1", bus.haz_seen); end
    n_checks++; if (bus.mode !== 2'b11) begin n_fail++; $display("FAIL clr_mode: got %b want 11", bus.mode); end
    step(LR_Z);
    n_checks++; if (bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL clr_state_err: got %b want 0", bus.seq_err); end
    n_checks++; if (bus.haz_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_haz_cnt_hold: got %0d want 0", bus.haz_cnt); end
  endtask

  task automatic test_reset_mid_sequence();
    do_reset();
    step(LR_Z);
    step(LR_A1);
    step(LR_A2);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    n_checks++; if (bus.in_sync !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sync: got %b want 0", bus.in_sync); end
    step(LR_A3);
    n_checks++; if (bus.left_done !== 1'b0) begin n_fail++; $display("FAIL mid_left_done: got %b want 0", bus.left_done); end
    n_checks++; if (bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL mid_seq_err: got %b want 0", bus.seq_err); end
    n_checks++; if (bus.in_sync !== 1'b0) begin n_fail++; $display("FAIL mid_a3_sync: got %b want 0", bus.in_sync); end
    n_checks++; if ({bus.left_cnt, bus.right_cnt, bus.haz_cnt, bus.err_cnt} !== 8'h00) begin
      n_fail++; $display("FAIL mid_counters: got %h want 00", {bus.left_cnt, bus.right_cnt, bus.haz_cnt, bus.err_cnt}); end
    step(LR_Z);
    n_checks++; if (bus.in_sync !== 1'b1) begin n_fail++; $display("FAIL mid_resync: got %b want 1", bus.in_sync); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.clr_cnt = 1'b0;
    {bus.L_lights, bus.R_lights} = LR_Z;
    test_reset();
    test_left_sequence();
    test_hazard_abort();
    test_illegal_pattern();
    test_illegal_transition();
    test_back_to_back();
    test_saturation_clear();
    test_reset_mid_sequence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before the end of the test sequence");
    $fatal(1, "watchdog expired");
  end

endmodule
